// File: rtl/fifo_wr_feeder_pkg.sv
// Shared definitions for the psum FIFO write-side feeder: state encoding and default widths.
package fifo_wr_feeder_pkg;

   localparam logic [1:0] STATE_IDLE   = 2'd0;
   localparam logic [1:0] STATE_STREAM = 2'd1;
   localparam logic [1:0] STATE_DRAIN  = 2'd2;

   localparam int SUM_BW_DEFAULT = 23;
   localparam int STALL_BW       = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = STATE_IDLE,
      ST_STREAM = STATE_STREAM,
      ST_DRAIN  = STATE_DRAIN
   } feeder_state_t;

endpackage

// File: rtl/fifo_skid_2.sv
// Two-entry register skid buffer; head is always the oldest buffered word.
module fifo_skid_2
   import fifo_wr_feeder_pkg::*;
#(
   parameter int bw = SUM_BW_DEFAULT
) (
   input  logic          wr_clk,
   input  logic          wr_rst,
   input  logic          push,
   input  logic [bw-1:0] push_data,
   input  logic          pop,
   output logic [bw-1:0] head,
   output logic [1:0]    occ
);

   logic [bw-1:0] head_q, head_d;
   logic [bw-1:0] tail_q, tail_d;
   logic [1:0]    occ_q, occ_d;
   logic          doPush, doPop;

   // Pop is applied first so a simultaneous push lands in whichever slot is free
   // afterwards; a push into a full buffer is only taken when a pop makes room.
   always_comb begin
      doPop  = pop && (occ_q != 2'd0);
      doPush = push && ((occ_q != 2'd2) || doPop);
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (doPop) begin
         if (occ_q == 2'd2) begin
            head_d = tail_q;
         end
         occ_d = occ_q - 2'd1;
      end
      if (doPush) begin
         if (occ_d == 2'd0) begin
            head_d = push_data;
         end else begin
            tail_d = push_data;
         end
         occ_d = occ_d + 2'd1;
      end
   end

   // Storage and occupancy registers
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head = head_q;
   assign occ  = occ_q;

endmodule

// File: rtl/fifo_wr_feeder.sv
// Write-side producer for the async psum FIFO: frames a valid/ready stream through
// a 2-entry skid buffer and never strobes the FIFO while it reports full.
module fifo_wr_feeder
   import fifo_wr_feeder_pkg::*;
#(
   parameter int SUM_BW    = SUM_BW_DEFAULT,
   parameter int FRAME_LEN = 16,
   parameter int CNT_BW    = 5
) (
   input  logic                wr_clk,
   input  logic                wr_rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [SUM_BW-1:0]   in_data,
   output logic                in_ready,
   input  logic                fifo_full,
   output logic                fifo_wr,
   output logic [SUM_BW-1:0]   fifo_in,
   output logic                busy,
   output logic                frame_done,
   output logic [CNT_BW-1:0]   words_sent,
   output logic [STALL_BW-1:0] stall_cnt
);

   localparam logic [CNT_BW-1:0] FrameLenC = CNT_BW'(FRAME_LEN);

   feeder_state_t       state_q;
   logic [CNT_BW-1:0]   accepted_q;
   logic [CNT_BW-1:0]   words_q;
   logic [STALL_BW-1:0] stall_q;
   logic                done_q;
   logic [1:0]          occ;
   logic [SUM_BW-1:0]   head;
   logic                push;
   logic                pop;

   // in_ready looks only at registers so upstream never sees a path from fifo_full
   assign in_ready   = (state_q == ST_STREAM) && (accepted_q < FrameLenC) && (occ != 2'd2);
   assign push       = in_valid && in_ready;
   assign pop        = (occ != 2'd0) && !fifo_full;
   assign fifo_wr    = pop;
   assign fifo_in    = head;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = done_q;
   assign words_sent = words_q;
   assign stall_cnt  = stall_q;

   fifo_skid_2 #(
      .bw(SUM_BW)
   ) u_skid (
      .wr_clk   (wr_clk),
      .wr_rst   (wr_rst),
      .push     (push),
      .push_data(in_data),
      .pop      (pop),
      .head     (head),
      .occ      (occ)
   );

   // Frame FSM with its counters; the frame closes on the write of the last word,
   // which can only happen after every word has been accepted.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_q    <= ST_IDLE;
         accepted_q <= '0;
         words_q    <= '0;
         stall_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop && (state_q != ST_IDLE)) begin
            words_q <= words_q + 1'b1;
         end
         if (fifo_full && (occ != 2'd0) && (stall_q != {STALL_BW{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_STREAM;
                  accepted_q <= '0;
                  words_q    <= '0;
                  stall_q    <= '0;
               end
            end
            ST_STREAM: begin
               if (push) begin
                  accepted_q <= accepted_q + 1'b1;
                  if (accepted_q == FrameLenC - 1'b1) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (pop && (words_q == FrameLenC - 1'b1)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
